// File: rtl/mem_bus_arb_pkg.sv
// Shared definitions for the instruction/data bus arbiter: FSM encodings,
// grant-history tags and the fixed word/byte-lane constants.
package mem_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_IF  = 2'd1,
        ST_GNT_MEM = 2'd2
    } state_e;

    typedef enum logic {
        LAST_IF  = 1'b0,
        LAST_MEM = 1'b1
    } grant_e;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [3:0]  SEL_NONE  = 4'h0;
    localparam logic [3:0]  SEL_WORD  = 4'hF;

endpackage

// File: rtl/mem_bus_arb.sv
// Arbitrates the instruction-fetch and load/store ports onto one shared bus,
// with MEM priority, IF anti-starvation, and a sticky watchdog timeout.
module mem_bus_arb
    import mem_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned BUS_AW  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [BUS_AW-1:0] if_addr_i,
    output logic [31:0]       if_rdata_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [BUS_AW-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_ack_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [BUS_AW-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    input  logic [31:0]       bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              stallreq_o,
    output logic              bus_err_o
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e            state_q, state_d;
    grant_e            last_q, last_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [BUS_AW-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              mem_ack_q, mem_ack_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              err_q, err_d;

    logic              if_pend, mem_pend;
    logic              grant_if, grant_mem;
    logic [7:0]        cnt_inc;

    // A requester still holds its request during its own ack cycle; that is
    // not a new request and must not win another grant.
    assign if_pend  = if_req_i  & ~if_ack_q;
    assign mem_pend = mem_req_i & ~mem_ack_q;
    assign cnt_inc  = cnt_q + 8'd1;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        err_d       = err_q;
        grant_if    = 1'b0;
        grant_mem   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_pend && !(last_q == LAST_MEM && if_pend)) begin
                    grant_mem = 1'b1;
                end else if (if_pend) begin
                    grant_if = 1'b1;
                end
            end
            ST_GNT_IF, ST_GNT_MEM: begin
                // Ack is checked first so a coincident ack beats the watchdog.
                if (bus_ack_i || cnt_inc == TIMEOUT_CNT) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    cnt_d     = 8'd0;
                    err_d     = err_q | ~bus_ack_i;
                    if (state_q == ST_GNT_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus_ack_i ? bus_rdata_i : ZERO_WORD;
                        grant_mem  = mem_pend;
                    end else begin
                        mem_ack_d   = 1'b1;
                        mem_rdata_d = (bus_ack_i && !bus_we_q) ? bus_rdata_i : ZERO_WORD;
                        grant_if    = if_pend;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant_mem) begin
            state_d     = ST_GNT_MEM;
            last_d      = LAST_MEM;
            cnt_d       = 8'd0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_we_i;
            bus_sel_d   = mem_sel_i;
            bus_addr_d  = mem_addr_i;
            bus_wdata_d = mem_wdata_i;
        end else if (grant_if) begin
            state_d     = ST_GNT_IF;
            last_d      = LAST_IF;
            cnt_d       = 8'd0;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_sel_d   = SEL_WORD;
            bus_addr_d  = if_addr_i;
            bus_wdata_d = ZERO_WORD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= LAST_IF;
            cnt_q       <= 8'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= SEL_NONE;
            bus_addr_q  <= '0;
            bus_wdata_q <= ZERO_WORD;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= ZERO_WORD;
            mem_rdata_q <= ZERO_WORD;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign if_ack_o    = if_ack_q;
    assign mem_ack_o   = mem_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign mem_rdata_o = mem_rdata_q;
    assign bus_err_o   = err_q;
    assign stallreq_o  = (mem_req_i & ~mem_ack_q) | (if_req_i & ~if_ack_q);

endmodule

// File: doc/mem_bus_arb.md
MEM_BUS_ARB -- requirements
Module: mem_bus_arb

Interface
REQ-001 Parameter TIMEOUT, default 255, bus-cycle watchdog limit in clocks (8-bit range, 1..255).
REQ-002 Parameter BUS_AW, default 32, bus address width.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 if_req_i  input  1  instruction fetch request, held until if_ack_o.
REQ-006 if_addr_i  input  BUS_AW  fetch address.
REQ-007 if_rdata_o  output  32  fetched word, valid with if_ack_o.
REQ-008 if_ack_o  output  1  one-cycle fetch completion pulse.
REQ-009 mem_req_i  input  1  load/store request from MEM stage, held until mem_ack_o.
REQ-010 mem_we_i  input  1  1 = store, 0 = load.
REQ-011 mem_sel_i  input  4  byte lane enables.
REQ-012 mem_addr_i  input  BUS_AW  load/store address.
REQ-013 mem_wdata_i  input  32  store data.
REQ-014 mem_rdata_o  output  32  load data, valid with mem_ack_o.
REQ-015 mem_ack_o  output  1  one-cycle load/store completion pulse.
REQ-016 bus_req_o / bus_we_o / bus_sel_o(4) / bus_addr_o(BUS_AW) / bus_wdata_o(32)  output  shared bus request and payload.
REQ-017 bus_rdata_i  input  32 / bus_ack_i  input  1  bus read data and completion.
REQ-018 stallreq_o  output  1  pipeline stall request to the pipeline control block.
REQ-019 bus_err_o  output  1  sticky watchdog-timeout flag.

Function
REQ-020 FSM states IDLE, GNT_IF, GNT_MEM; all bus_* and ack/rdata outputs SHALL be registered.
REQ-021 IDLE: mem_req_i wins over if_req_i, except when the previous grant was GNT_MEM and if_req_i is high, then IF wins (anti-starvation).
REQ-022 On grant, requester payload SHALL be latched and bus_req_o asserted the following cycle; payload SHALL stay stable until bus_ack_i.
REQ-023 On bus_ack_i in GNT_x: next edge drops bus_req_o, pulses x_ack_o for exactly one cycle, and loads x_rdata_o with bus_rdata_i (0 for stores).
REQ-024 On that same edge, if the other requester is pending, grant it directly (no IDLE cycle); else return to IDLE.
REQ-025 Minimum latency with zero-wait bus: request sampled cycle N, bus_req_o at N+1, ack at N+2 if bus acks at N+1.
REQ-026 Watchdog: 8-bit counter cleared on grant, incremented every GNT_x cycle without bus_ack_i; reaching TIMEOUT SHALL abort: drop bus_req_o, pulse x_ack_o with x_rdata_o = 0, set bus_err_o.
REQ-027 bus_ack_i in the same cycle the counter reaches TIMEOUT SHALL complete normally (ack beats timeout), bus_err_o unchanged.
REQ-028 bus_ack_i while in IDLE SHALL be ignored.
REQ-029 Requester dropping x_req_i mid-transaction: bus cycle still completes, x_ack_o still pulses.
REQ-030 stallreq_o = (mem_req_i AND NOT mem_ack_o) OR (if_req_i AND NOT if_ack_o), combinational.
REQ-031 bus_err_o, once set, SHALL remain 1 until rst.

Reset
REQ-032 rst high SHALL immediately force state IDLE, bus_req_o/bus_we_o/if_ack_o/mem_ack_o/bus_err_o = 0, bus_sel_o = 0, all address/data outputs = 0, counter = 0, last-grant = IF.
REQ-033 rst asserted mid-transaction SHALL abandon it with no ack pulse after release.

Structure
REQ-034 State encodings, ZeroWord, and byte-select constants SHALL live in the shared defines file; TIMEOUT stays a module parameter.
REQ-035 Single flat module; no sub-module.

Verification
REQ-036 Only if_req_i, addr 0x0000_0100, bus acks 1 cycle later with 0x0000_0013 -> if_ack_o pulse, if_rdata_o = 0x0000_0013, stallreq_o low after ack.
REQ-037 if_req_i and mem_req_i (store, sel 0xF, addr 0x1000, data 0xDEADBEEF) same cycle -> MEM served first, then IF back-to-back without IDLE cycle.
REQ-038 Continuous mem_req_i plus if_req_i -> grants alternate MEM, IF, MEM; IF never waits more than one MEM transaction.
REQ-039 Bus never acks, TIMEOUT = 4 -> abort after 4 grant cycles, x_ack_o pulse, rdata 0, bus_err_o = 1 and sticky.
REQ-040 bus_ack_i coincident with counter = TIMEOUT -> normal completion, bus_err_o = 0.
REQ-041 rst pulse while bus_req_o = 1 -> bus_req_o falls without waiting for clk, no ack afterwards.
